// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Purpose  : Shared definitions for the UART transmit path: default data
//            width / depth and the load/wait state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_LOGD     = 4;
  localparam int DEF_AFULL_TH = 12;

  // IDLE: free to load the next byte; WAIT: a byte is with the UART
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : fifo_core
// Purpose  : DEPTH x W circular queue with occupancy count, sticky overflow
//            and synchronous flush. Read data is the entry at rd_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_core
  import uart_tx_fifo_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LOGD  = DEF_LOGD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [W-1:0]  rd_data,
  output logic [LOGD:0] count,
  output logic          empty,
  output logic          overflow
);

  localparam logic [LOGD:0] FULL_CNT = (LOGD+1)'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [LOGD-1:0] wr_ptr;
  logic [LOGD-1:0] rd_ptr;
  logic            full;
  logic            push;
  logic            pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // accepted then. Flush wins over both.
  assign pop     = rd_en && !empty && !flush;
  assign push    = wr_en && !flush && (!full || pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush rewinds everything to slot 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Sticky drop flag: only a non-flush push that could not be stored sets it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && !flush && !push) begin
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Transmit FIFO between the encoder and uart_trans. Buffers bytes,
//            raises a threshold stall and hands bytes to the UART using the
//            write_TDR / trans_done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOGD     = DEF_LOGD,
  parameter int AFULL_TH = DEF_AFULL_TH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_in,
  input  logic          data_enable,
  input  logic          flush,
  input  logic          trans_done,
  output logic [W-1:0]  data_out,
  output logic          write_TDR,
  output logic          stall,
  output logic          idle,
  output logic [LOGD:0] count,
  output logic          overflow
);

  localparam logic [LOGD:0] AFULL_CNT = (LOGD+1)'(AFULL_TH);

  tx_state_e      state;
  tx_state_e      state_nxt;
  logic           load;
  logic           empty;
  logic [W-1:0]   rd_data;

  fifo_core #(
    .W     (W),
    .DEPTH (DEPTH),
    .LOGD  (LOGD)
  ) u_fifo_core (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (data_enable),
    .wr_data  (data_in),
    .rd_en    (load),
    .flush    (flush),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .overflow (overflow)
  );

  // Load/wait state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: load a byte whenever idle with data queued (flush blocks it);
  // a trans_done seen while idle is simply ignored
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !flush) begin
          load      = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trans_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered UART interface: strobe and byte appear together one edge
  // after the load decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      write_TDR <= 1'b0;
    end else begin
      write_TDR <= load;
      if (load) data_out <= rd_data;
    end
  end

  assign stall = (count >= AFULL_CNT);
  assign idle  = (count == '0) && (state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int W        = 8;
  localparam int DEPTH    = 16;
  localparam int LOGD     = 4;
  localparam int AFULL_TH = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_enable = 1'b0;
  logic         flush = 1'b0;
  logic         trans_done = 1'b0;
  logic [W-1:0] data_out;
  logic         write_TDR;
  logic         stall;
  logic         idle;
  logic [LOGD:0] count;
  logic         overflow;

  // Small instance for wrap-around: DEPTH=4, AFULL_TH=3
  logic [7:0] d4_in = '0;
  logic       d4_en = 1'b0;
  logic       d4_flush = 1'b0;
  logic       d4_td = 1'b0;
  logic [7:0] d4_out;
  logic       d4_wtdr;
  logic       d4_stall;
  logic       d4_idle;
  logic [2:0] d4_count;
  logic       d4_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: queue of waiting bytes plus "a byte is with the UART"
  logic [7:0] mq[$];
  logic       m_busy;
  logic       m_ovf;
  logic       m_wtdr;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  uart_tx_fifo #(.W(W), .DEPTH(DEPTH), .LOGD(LOGD), .AFULL_TH(AFULL_TH)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_enable(data_enable),
    .flush(flush), .trans_done(trans_done), .data_out(data_out),
    .write_TDR(write_TDR), .stall(stall), .idle(idle), .count(count),
    .overflow(overflow)
  );

  uart_tx_fifo #(.W(8), .DEPTH(4), .LOGD(2), .AFULL_TH(3)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(d4_in), .data_enable(d4_en),
    .flush(d4_flush), .trans_done(d4_td), .data_out(d4_out),
    .write_TDR(d4_wtdr), .stall(d4_stall), .idle(d4_idle), .count(d4_count),
    .overflow(d4_ovf)
  );

  task automatic model_clear();
    mq.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    m_wtdr = 1'b0;
    m_dout = '0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, sample at +1
  task automatic cycle(input logic en, input logic [7:0] d, input logic fl, input logic td);
    logic go;
    data_enable = en; data_in = d; flush = fl; trans_done = td;
    @(posedge clk);
    m_wtdr = 1'b0;
    go = !m_busy && (mq.size() > 0) && !fl;
    if (m_busy && td) m_busy = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (go) begin
        m_dout = mq.pop_front();
        m_wtdr = 1'b1;
        m_busy = 1'b1;
      end
      if (en) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    data_enable = 1'b0; flush = 1'b0; trans_done = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (write_TDR !== 1'b0) begin n_fail++; $display("FAIL reset_wtdr: got %b expected 0", write_TDR); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", data_out); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (idle !== 1'b1 || write_TDR !== 1'b0) begin
        n_fail++; $display("FAIL idle_td_ignored: got idle=%b wtdr=%b expected idle=1 wtdr=0", idle, write_TDR);
      end
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    n_checks++; if (write_TDR !== 1'b0 || count !== 5'd1) begin
      n_fail++; $display("FAIL single_edge1: got wtdr=%b count=%0d expected wtdr=0 count=1", write_TDR, count);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (write_TDR !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL single_load: got wtdr=%b dout=%0h expected wtdr=1 dout=a5", write_TDR, data_out);
    end
    n_checks++; if (idle !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL single_wait: got idle=%b count=%0d expected idle=0 count=0", idle, count);
    end
    for (int i = 3; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (write_TDR !== 1'b0 || idle !== 1'b0) begin
        n_fail++; $display("FAIL single_hold: got wtdr=%b idle=%b expected wtdr=0 idle=0", write_TDR, idle);
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (idle !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL single_done: got idle=%b dout=%0h expected idle=1 dout=a5", idle, data_out);
    end
  endtask

  task automatic test_burst();
    int e = 0, last_load = 0, got = 0;
    logic td;
    while ((got < 16 || m_busy) && e < 400) begin
      e++;
      td = m_busy && (e - last_load == 8);
      cycle(e <= 16, 8'(e - 1), 1'b0, td);
      if (m_wtdr) last_load = e;
      n_checks++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL burst_count: got %0d expected %0d", count, mq.size()); end
      n_checks++; if (write_TDR !== m_wtdr) begin n_fail++; $display("FAIL burst_wtdr: got %b expected %b", write_TDR, m_wtdr); end
      n_checks++; if (stall !== (mq.size() >= AFULL_TH)) begin n_fail++; $display("FAIL burst_stall: got %b count %0d", stall, mq.size()); end
      n_checks++; if (idle !== (mq.size() == 0 && !m_busy)) begin n_fail++; $display("FAIL burst_idle: got %b", idle); end
      if (write_TDR) begin
        n_checks++; if (data_out !== 8'(got)) begin n_fail++; $display("FAIL burst_order: got %0h expected %0h", data_out, got); end
        got++;
      end
    end
    n_checks++; if (got !== 16) begin n_fail++; $display("FAIL burst_total: got %0d expected 16", got); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    n_checks++; if (count !== 5'd5 || idle !== 1'b0 || data_out !== 8'h50) begin
      n_fail++; $display("FAIL flush_setup: got count=%0d idle=%b dout=%0h expected 5/0/50", count, idle, data_out);
    end
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got count=%0d ovf=%b expected 0/0", count, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (write_TDR !== 1'b0 || idle !== 1'b0 || data_out !== 8'h50) begin
        n_fail++; $display("FAIL flush_inflight: got wtdr=%b idle=%b dout=%0h expected 0/0/50", write_TDR, idle, data_out);
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL flush_done_idle: got %b expected 1", idle); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (write_TDR !== 1'b0 || count !== 5'd0) begin
        n_fail++; $display("FAIL flush_residue: got wtdr=%b count=%0d expected 0/0", write_TDR, count);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp4[$];
    logic [7:0] v, e;
    int sent = 0, got = 0, cyc = 0;
    logic td_next = 1'b0;
    while (got < 40 && cyc < 1000) begin
      cyc++;
      d4_en = (sent < 40) && !d4_stall;
      v = 8'($urandom);
      d4_in = v;
      if (d4_en) begin exp4.push_back(v); sent++; end
      d4_td = td_next;
      td_next = 1'b0;
      @(posedge clk);
      #1;
      d4_en = 1'b0; d4_td = 1'b0;
      n_checks++; if (d4_count > 3'd4) begin n_fail++; $display("FAIL wrap_count: got %0d expected <=4", d4_count); end
      if (d4_wtdr) begin
        e = (exp4.size() > 0) ? exp4.pop_front() : 8'hxx;
        n_checks++; if (d4_out !== e) begin n_fail++; $display("FAIL wrap_order: got %0h expected %0h", d4_out, e); end
        got++;
        td_next = 1'b1;
      end
    end
    d4_td = 1'b1;
    @(posedge clk);
    #1 d4_td = 1'b0;
    n_checks++; if (got !== 40) begin n_fail++; $display("FAIL wrap_total: got %0d expected 40", got); end
    n_checks++; if (d4_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", d4_ovf); end
    n_checks++; if (d4_idle !== 1'b1 || d4_count !== 3'd0) begin
      n_fail++; $display("FAIL wrap_end: got idle=%b count=%0d expected 1/0", d4_idle, d4_count);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    logic ff_seen = 1'b0;
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill: got count=%0d ovf=%b expected 16/0", count, overflow);
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop: got count=%0d ovf=%b expected 16/1", count, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16 || write_TDR !== 1'b1 || data_out !== 8'h01) begin
      n_fail++; $display("FAIL ovf_pushpop: got count=%0d wtdr=%b dout=%0h expected 16/1/01", count, write_TDR, data_out);
    end
    while ((mq.size() > 0 || m_busy) && n < 400) begin
      n++;
      cycle(1'b0, 8'h00, 1'b0, m_busy && !m_wtdr);
      n_checks++; if (write_TDR !== m_wtdr || data_out !== m_dout) begin
        n_fail++; $display("FAIL ovf_drain: got wtdr=%b dout=%0h expected %b/%0h", write_TDR, data_out, m_wtdr, m_dout);
      end
      if (write_TDR && data_out === 8'hFF) ff_seen = 1'b1;
    end
    n_checks++; if (ff_seen !== 1'b0) begin n_fail++; $display("FAIL ovf_ff_out: got %b expected 0", ff_seen); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (overflow !== 1'b1 || idle !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b idle=%b expected 1/1", overflow, idle);
    end
  endtask

  task automatic test_random();
    logic en, fl, td;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 3);
      td = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cycle(en, 8'($urandom), fl, td);
      n_checks++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count, mq.size()); end
      n_checks++; if (write_TDR !== m_wtdr) begin n_fail++; $display("FAIL rand_wtdr: got %b expected %b", write_TDR, m_wtdr); end
      n_checks++; if (data_out !== m_dout) begin n_fail++; $display("FAIL rand_dout: got %0h expected %0h", data_out, m_dout); end
      n_checks++; if (stall !== (mq.size() >= AFULL_TH)) begin n_fail++; $display("FAIL rand_stall: got %b count %0d", stall, mq.size()); end
      n_checks++; if (idle !== (mq.size() == 0 && !m_busy)) begin n_fail++; $display("FAIL rand_idle: got %b", idle); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (idle !== 1'b1 || count !== 5'd0 || write_TDR !== 1'b0 || data_out !== 8'h00 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got idle=%b count=%0d wtdr=%b dout=%0h ovf=%b expected 1/0/0/0/0",
                         idle, count, write_TDR, data_out, overflow);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (write_TDR !== 1'b0 || idle !== 1'b1) begin
        n_fail++; $display("FAIL reset_mid_after: got wtdr=%b idle=%b expected 0/1", write_TDR, idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_flush();
    test_wrap();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
